param_seq_detector: RTL and testbench
=====================================

# param_seq_detector

Parametrised Moore serial-pattern detector, next generation of the team's fixed-pattern detector. Pattern length, default pattern and counter width are compile-time parameters. Pattern and don't-care mask are runtime-loadable; overlapping versus non-overlapping detection is runtime-selectable; a valid qualifier on the input stream is supported; a saturating match counter is provided. The block sits between a serial bit source and the control logic that consumes match events.

## Interface
- SEQ_LEN, 5: pattern length in bits, 1..32.
- DEFAULT_PATTERN, 5'b10010: pattern after reset. The MSB is the first bit received.
- DEFAULT_MASK, all ones: care mask after reset. A 1 means the bit must match; a 0 means don't-care.
- CNT_W, 8: width of match_count.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- din  in  1  serial data bit.
- din_valid  in  1  din is sampled only when this is high.
- load  in  1  when high, pattern_in and mask_in are latched and detection state is cleared.
- pattern_in  in  SEQ_LEN  new pattern, MSB first in time.
- mask_in  in  SEQ_LEN  new care mask.
- overlap  in  1  1 selects overlapping detection; 0 selects non-overlapping.
- detected  out  1  registered Moore match flag.
- match_count  out  CNT_W  saturating count of detections since reset or load.
- fill  out  clog2(SEQ_LEN+1)  number of history bits currently eligible, saturating at SEQ_LEN.

## Operation
- State: history shift register hist[SEQ_LEN-1:0]. The newest bit enters at the LSB. Also held: fill counter, active pattern register pat, active mask register msk, detected register, match_count register.
- Reset (reset_n low, asynchronous) clears:
  - hist, fill, detected and match_count to 0.
  - pat set to DEFAULT_PATTERN; msk set to DEFAULT_MASK.
- Load (load high at a clock edge) has highest priority after reset:
  - pat takes pattern_in; msk takes mask_in.
  - hist, fill, detected and match_count cleared to 0.
  - din on that edge is discarded, even if din_valid is high.
- Sample (din_valid high, load low):
  - next_hist = {hist[SEQ_LEN-2:0], din}. For SEQ_LEN=1, next_hist = din.
  - next_fill = min(fill+1, SEQ_LEN).
  - Match condition: next_fill == SEQ_LEN and ((next_hist ^ pat) & msk) == 0.
  - On match, detected is set to 1 and match_count increments, saturating at 2^CNT_W-1.
  - On match with overlap=0, fill is set to 0: bits of the matched window are not reused.
  - On match with overlap=1, fill stays at SEQ_LEN.
  - On no match, detected is set to 0.
- Idle (din_valid low, load low): hist, fill and match_count hold; detected is set to 0.
- The overlap input is sampled every edge. Changing it mid-stream affects only matches decided on that edge and later.
- An all-zero mask matches any window once fill reaches SEQ_LEN.

## Timing
- The decision is made on the edge that samples the final pattern bit. detected is high for exactly the following clock period.
- Latency: 1 clock from the sampling edge to detected, and to the updated match_count.
- With overlap=1 and a self-overlapping pattern, back-to-back matches hold detected high for consecutive cycles. Example: pattern 11111 with a continuous stream of 1s.
- Bubbles (din_valid low) extend the wait without losing history. detected is never high in a cycle that follows a bubble.
- reset_n assertion clears all outputs immediately, without waiting for a clock edge. Deassertion is synchronised externally by the system reset logic.
- Reset values of all outputs: detected=0, match_count=0, fill=0.

## Test plan
- Default pattern 10010, overlap=1, din_valid held high, stream 0010010010 -> detected pulses after the 7th and 10th bits; match_count=2.
- Same stream with overlap=0 -> detected pulses only after the 7th bit; match_count=1; fill=3 at the end.
- Load pattern 11111 with mask 11111, overlap=1, then six 1s -> detected high for 2 consecutive cycles (after bits 5 and 6); match_count=2. Repeat with overlap=0 -> a single pulse; match_count=1.
- Load pattern 10010 with mask 10111, stream 11010 -> match, because bit 3 is don't-care. Then assert load together with din_valid -> that din is discarded, and fill=0 and match_count=0.
- Pattern 10010 delivered with din_valid low for 3 cycles between each bit -> exactly one detected pulse, one cycle after the final sampling edge; fill holds during the gaps.
- Two cases with CNT_W=2:
  - Reset asserted after 100 of 10010 has been received, then 10 sent after release -> no detection.
  - Five separate 10010 sequences -> match_count saturates at 3.

Source files
------------

// File: rtl/param_seq_detector.sv
// param_seq_detector
// Parametrised Moore serial-pattern detector. A history shift register
// collects qualified input bits (newest at the LSB); once enough bits have
// been seen, the window is compared against a runtime-loadable pattern under
// a don't-care mask. The match flag and a saturating match counter are
// registered, so both appear one clock after the sampling edge.

// Single-bit compare cell: flags a cared-about bit that differs from the pattern.
module param_seq_detector_bit (
    input  logic hist_bit,
    input  logic pat_bit,
    input  logic msk_bit,
    output logic miss
);

    assign miss = (hist_bit ^ pat_bit) & msk_bit;

endmodule

module param_seq_detector #(
    parameter int                 SEQ_LEN         = 5,
    parameter logic [SEQ_LEN-1:0] DEFAULT_PATTERN = SEQ_LEN'(5'b10010),
    parameter logic [SEQ_LEN-1:0] DEFAULT_MASK    = {SEQ_LEN{1'b1}},
    parameter int                 CNT_W           = 8
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               din,
    input  logic                               din_valid,
    input  logic                               load,
    input  logic [SEQ_LEN-1:0]                 pattern_in,
    input  logic [SEQ_LEN-1:0]                 mask_in,
    input  logic                               overlap,
    output logic                               detected,
    output logic [CNT_W-1:0]                   match_count,
    output logic [$clog2(SEQ_LEN+1)-1:0]       fill
);

    localparam int                FILL_W    = $clog2(SEQ_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SEQ_LEN);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    // Architectural state
    logic [SEQ_LEN-1:0] hist;
    logic [SEQ_LEN-1:0] pat;
    logic [SEQ_LEN-1:0] msk;
    logic [FILL_W-1:0]  fill_q;
    logic               det_q;
    logic [CNT_W-1:0]   cnt_q;

    // Next-edge view of the window, used for the decision on the sampling edge
    logic [SEQ_LEN-1:0] next_hist;
    logic [FILL_W-1:0]  next_fill;
    logic [SEQ_LEN-1:0] miss;
    logic               window_full;
    logic               match;

    // A one-bit pattern has no older history to keep, so the window is just din.
    generate
        if (SEQ_LEN == 1) begin : g_hist_one
            assign next_hist = din;
        end else begin : g_hist_shift
            assign next_hist = {hist[SEQ_LEN-2:0], din};
        end
    endgenerate

    assign next_fill   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
    assign window_full = (next_fill == FILL_FULL);

    // One compare cell per pattern bit; any flagged miss kills the match.
    genvar gi;
    generate
        for (gi = 0; gi < SEQ_LEN; gi++) begin : g_cmp
            param_seq_detector_bit u_bit (
                .hist_bit (next_hist[gi]),
                .pat_bit  (pat[gi]),
                .msk_bit  (msk[gi]),
                .miss     (miss[gi])
            );
        end
    endgenerate

    // A match is only meaningful on an edge that actually samples din.
    assign match = din_valid && !load && window_full && (miss == '0);

    // Active pattern and mask: defaults out of reset, replaced on load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pat <= DEFAULT_PATTERN;
            msk <= DEFAULT_MASK;
        end else if (load) begin
            pat <= pattern_in;
            msk <= mask_in;
        end
    end

    // History and fill: shift on valid samples; a non-overlapping match
    // empties the window so its bits cannot contribute to the next match.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist   <= '0;
            fill_q <= '0;
        end else if (load) begin
            hist   <= '0;
            fill_q <= '0;
        end else if (din_valid) begin
            hist <= next_hist;
            if (match && !overlap) begin
                fill_q <= '0;
            end else begin
                fill_q <= next_fill;
            end
        end
    end

    // Moore outputs: detected follows the decision of the previous edge and
    // drops on bubbles; the counter saturates instead of wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            det_q <= 1'b0;
            cnt_q <= '0;
        end else if (load) begin
            det_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            det_q <= match;
            if (match && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign detected    = det_q;
    assign match_count = cnt_q;
    assign fill        = fill_q;

endmodule

// File: tb/tb_param_seq_detector.sv
// Directed bench for param_seq_detector: one default instance (CNT_W=8) and
// one narrow-counter instance (CNT_W=2) share the clock. Expected values are
// hand-derived from the pattern/stream pairs below.
module tb_param_seq_detector;

    logic       clk = 1'b0;
    int         n_checks = 0;
    int         n_fail   = 0;

    // Instance A: default parameters
    logic       reset_n, din, din_valid, load, overlap;
    logic [4:0] pattern_in, mask_in;
    logic       detected;
    logic [7:0] match_count;
    logic [2:0] fill;

    // Instance B: CNT_W = 2
    logic       reset_n2, din2, din_valid2, load2, overlap2;
    logic [4:0] pattern_in2, mask_in2;
    logic       detected2;
    logic [1:0] match_count2;
    logic [2:0] fill2;

    always #5 clk = ~clk;

    param_seq_detector dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .din         (din),
        .din_valid   (din_valid),
        .load        (load),
        .pattern_in  (pattern_in),
        .mask_in     (mask_in),
        .overlap     (overlap),
        .detected    (detected),
        .match_count (match_count),
        .fill        (fill)
    );

    param_seq_detector #(.CNT_W(2)) dut2 (
        .clk         (clk),
        .reset_n     (reset_n2),
        .din         (din2),
        .din_valid   (din_valid2),
        .load        (load2),
        .pattern_in  (pattern_in2),
        .mask_in     (mask_in2),
        .overlap     (overlap2),
        .detected    (detected2),
        .match_count (match_count2),
        .fill        (fill2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive on the falling edge, let the rising edge act, look #1 later.
    task automatic step(input logic d, input logic v);
        @(negedge clk);
        din = d; din_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic step2(input logic d, input logic v);
        @(negedge clk);
        din2 = d; din_valid2 = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [4:0] p, input logic [4:0] m);
        @(negedge clk);
        load = 1'b1; pattern_in = p; mask_in = m; din_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic do_load2(input logic [4:0] p, input logic [4:0] m);
        @(negedge clk);
        load2 = 1'b1; pattern_in2 = p; mask_in2 = m; din_valid2 = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        load2 = 1'b0;
    endtask

    initial begin
        logic [9:0] s10;
        logic [9:0] e10;
        logic [4:0] s5;
        logic [4:0] p5;

        reset_n = 1'b0; din = 1'b0; din_valid = 1'b0; load = 1'b0; overlap = 1'b1;
        pattern_in = 5'b0; mask_in = 5'b0;
        reset_n2 = 1'b0; din2 = 1'b0; din_valid2 = 1'b0; load2 = 1'b0; overlap2 = 1'b0;
        pattern_in2 = 5'b0; mask_in2 = 5'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset detected", detected, 0);
        check("reset count", match_count, 0);
        check("reset fill", fill, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // 1: default pattern, overlapping, pulses after bits 7 and 10
        s10 = 10'b0010010010;
        e10 = 10'b0000001001;
        overlap = 1'b1;
        for (int k = 9; k >= 0; k--) begin
            step(s10[k], 1'b1);
            check($sformatf("ovl det bit%0d", 10 - k), detected, e10[k]);
        end
        check("ovl count", match_count, 2);
        check("ovl fill", fill, 5);

        // Asynchronous reset clears outputs before any clock edge
        @(negedge clk);
        din_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("async count", match_count, 0);
        check("async fill", fill, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // 2: same stream, non-overlapping, single pulse after bit 7
        overlap = 1'b0;
        e10 = 10'b0000001000;
        for (int k = 9; k >= 0; k--) begin
            step(s10[k], 1'b1);
            check($sformatf("novl det bit%0d", 10 - k), detected, e10[k]);
        end
        check("novl count", match_count, 1);
        check("novl fill", fill, 3);

        // 3: pattern 11111, six ones, overlapping then non-overlapping
        do_load(5'b11111, 5'b11111);
        check("load fill", fill, 0);
        check("load count", match_count, 0);
        overlap = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, 1'b1);
            check($sformatf("ones ovl det bit%0d", k), detected, (k >= 5) ? 1 : 0);
        end
        check("ones ovl count", match_count, 2);
        do_load(5'b11111, 5'b11111);
        overlap = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, 1'b1);
            check($sformatf("ones novl det bit%0d", k), detected, (k == 5) ? 1 : 0);
        end
        check("ones novl count", match_count, 1);
        check("ones novl fill", fill, 1);

        // 4: mask with a don't-care bit; 11010 matches 10010/10111
        do_load(5'b10010, 5'b10111);
        overlap = 1'b1;
        s5 = 5'b11010;
        for (int k = 4; k >= 0; k--) begin
            step(s5[k], 1'b1);
            check($sformatf("mask det bit%0d", 5 - k), detected, (k == 0) ? 1 : 0);
        end
        check("mask count", match_count, 1);
        // load together with a valid bit: the bit is discarded
        @(negedge clk);
        load = 1'b1; din = 1'b1; din_valid = 1'b1;
        pattern_in = 5'b10010; mask_in = 5'b10111;
        @(posedge clk);
        #1;
        check("load+valid fill", fill, 0);
        check("load+valid count", match_count, 0);
        check("load+valid det", detected, 0);
        @(negedge clk);
        load = 1'b0; din_valid = 1'b0;

        // 5: pattern delivered with three bubbles after each bit
        do_load(5'b10010, 5'b11111);
        p5 = 5'b10010;
        for (int k = 4; k >= 0; k--) begin
            step(p5[k], 1'b1);
            check($sformatf("bub det bit%0d", 5 - k), detected, (k == 0) ? 1 : 0);
            check($sformatf("bub fill bit%0d", 5 - k), fill, 5 - k);
            for (int g = 0; g < 3; g++) begin
                step(1'b0, 1'b0);
                check($sformatf("bub gap det bit%0d g%0d", 5 - k, g), detected, 0);
                check($sformatf("bub gap fill bit%0d g%0d", 5 - k, g), fill, 5 - k);
            end
        end
        check("bub count", match_count, 1);

        // 6: CNT_W=2 instance, reset mid-pattern then partial tail
        @(negedge clk);
        reset_n2 = 1'b1;
        overlap2 = 1'b0;
        step2(1'b1, 1'b1);
        step2(1'b0, 1'b1);
        step2(1'b0, 1'b1);
        check("n2 pre-reset fill", fill2, 3);
        @(negedge clk);
        din_valid2 = 1'b0;
        reset_n2 = 1'b0;
        #1;
        check("n2 async fill", fill2, 0);
        @(negedge clk);
        reset_n2 = 1'b1;
        step2(1'b1, 1'b1);
        check("n2 tail det0", detected2, 0);
        step2(1'b0, 1'b1);
        check("n2 tail det1", detected2, 0);
        check("n2 tail fill", fill2, 2);
        check("n2 tail count", match_count2, 0);

        // Five separate matches saturate a 2-bit counter at 3
        do_load2(5'b10010, 5'b11111);
        for (int r = 1; r <= 5; r++) begin
            for (int k = 4; k >= 0; k--) begin
                step2(p5[k], 1'b1);
            end
            check($sformatf("n2 rep%0d det", r), detected2, 1);
            check($sformatf("n2 rep%0d count", r), match_count2, (r > 3) ? 3 : r);
        end
        step2(1'b0, 1'b0);
        check("n2 idle det", detected2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
